// File: rtl/layer2_out_packer.sv
// layer2_out_packer: applies optional ReLU to 16-bit lanes and packs M2/M beats per BRAM word, counting words per frame.
module layer2_out_packer #(
    parameter int M           = 16,
    parameter int M2          = 64,
    parameter int ADDR_WIDTH  = 10,
    parameter int FRAME_WORDS = 196,
    parameter bit RELU        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [M*16-1:0]       in_data,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [M2*16-1:0]      bram_din,
    output logic                  busy,
    output logic                  done,
    output logic                  seq_err
);
    localparam int B  = M2 / M;
    localparam int BW = B > 1 ? $clog2(B) : 1;

    if (M2 % M != 0) begin : g_chk_lanes
        $error("M2 must be a multiple of M");
    end
    if (FRAME_WORDS > (1 << ADDR_WIDTH)) begin : g_chk_frame
        $error("FRAME_WORDS exceeds BRAM address space");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    state_t state, state_nx;

    logic [BW-1:0]         beat_cnt;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [M2*16-1:0]      pack, word_full;
    logic [M*16-1:0]       beat;
    logic                  accept, last_beat, last_word;

    for (genvar k = 0; k < M; k++) begin : g_lane
        assign beat[16*k +: 16] = (RELU && in_data[16*k+15]) ? 16'h0000 : in_data[16*k +: 16];
    end

    assign accept    = (state == COLLECT) && in_valid;
    assign last_beat = accept && (beat_cnt == BW'(B-1));
    assign last_word = word_cnt == ADDR_WIDTH'(FRAME_WORDS-1);
    assign busy      = state != IDLE;

    // The incoming beat is merged combinationally so the final slot lands in bram_din on the same edge.
    always_comb begin
        word_full = pack;
        word_full[beat_cnt*M*16 +: M*16] = beat;
    end

    always_comb begin
        state_nx = (state == IDLE && start)                  ? COLLECT :
                   (state == COLLECT && last_beat && last_word) ? DONE :
                   (state == DONE)                           ? IDLE    : state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            word_cnt  <= '0;
            pack      <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            done      <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            bram_we <= last_beat;
            done    <= state == DONE;
            if (state == IDLE && start) begin
                beat_cnt <= '0;
                word_cnt <= '0;
                seq_err  <= 1'b0;
            end else if (state != COLLECT && in_valid) begin
                seq_err <= 1'b1;
            end
            if (accept) begin
                pack     <= word_full;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (last_beat) begin
                bram_din  <= word_full;
                bram_addr <= word_cnt;
                word_cnt  <= last_word ? '0 : word_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_layer2_out_packer.sv
// tb_layer2_out_packer: directed checks of packing, ReLU, gaps, frame completion and sequencing errors.
module tb_layer2_out_packer;
    logic           clk = 0;
    logic           rst = 0;
    logic           start = 0;
    logic           in_valid = 0;
    logic [255:0]   in_data = '0;
    logic           we_a, busy_a, done_a, err_a;
    logic [9:0]     addr_a;
    logic [1023:0]  din_a;
    logic           we_b, busy_b, done_b, err_b;
    logic [9:0]     addr_b;
    logic [1023:0]  din_b;
    int             checks = 0;
    int             errors = 0;
    int             we_cnt = 0;
    int             done_cnt = 0;
    int             base_we, base_done;

    always #5 clk = ~clk;

    layer2_out_packer #(.FRAME_WORDS(4), .RELU(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .bram_we(we_a), .bram_addr(addr_a), .bram_din(din_a), .busy(busy_a), .done(done_a), .seq_err(err_a)
    );

    layer2_out_packer #(.FRAME_WORDS(4), .RELU(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .bram_we(we_b), .bram_addr(addr_b), .bram_din(din_b), .busy(busy_b), .done(done_b), .seq_err(err_b)
    );

    always @(negedge clk) begin
        if (we_a) we_cnt++;
        if (done_a) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        for (int i = 0; i < 16; i++) chk($sformatf("%s[%0d]", tag, i), obs[64*i +: 64], exp[64*i +: 64]);
    endtask

    task automatic send(input logic [255:0] d);
        in_valid = 1;
        in_data  = d;
        tick();
        in_valid = 0;
    endtask

    task automatic pulse_start;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic do_reset;
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    function automatic logic [255:0] mk(input int j);
        logic [255:0] d;
        for (int k = 0; k < 16; k++) d[16*k +: 16] = 16'(16*j + k + 1);
        return d;
    endfunction

    function automatic logic [1023:0] exp_basic();
        logic [1023:0] w;
        for (int l = 0; l < 64; l++) w[16*l +: 16] = 16'(l + 1);
        return w;
    endfunction

    function automatic logic [255:0] relu_beat();
        logic [255:0] d;
        for (int k = 0; k < 16; k++) d[16*k +: 16] = (k % 3 == 0) ? 16'hFFFF : (k % 3 == 1) ? 16'h8000 : 16'h7FFF;
        return d;
    endfunction

    function automatic logic [1023:0] relu_exp(input bit relu);
        logic [1023:0] w;
        for (int l = 0; l < 64; l++)
            w[16*l +: 16] = ((l % 16) % 3 == 2) ? 16'h7FFF : !relu ? (((l % 16) % 3 == 0) ? 16'hFFFF : 16'h8000) : 16'h0000;
        return w;
    endfunction

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_we", 64'(we_a), 64'd0);
        chk("rst_addr", 64'(addr_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk_word("rst_din", din_a, '0);
        rst = 1;

        // reset mid-frame, then a fresh word
        pulse_start();
        chk("mid_busy", 64'(busy_a), 64'd1);
        send({16{16'h1111}});
        send({16{16'h2222}});
        do_reset();
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_we", 64'(we_a), 64'd0);
        chk("mid_rst_err", 64'(err_a), 64'd0);
        base_we = we_cnt;
        pulse_start();
        for (int j = 0; j < 3; j++) send(mk(j));
        chk("basic_no_early_we", 64'(we_a), 64'd0);
        send(mk(3));
        chk("basic_we", 64'(we_a), 64'd1);
        chk("basic_addr", 64'(addr_a), 64'd0);
        chk_word("basic_din", din_a, exp_basic());
        tick();
        chk("basic_we_one_cycle", 64'(we_a), 64'd0);
        chk("basic_we_count", 64'(we_cnt - base_we), 64'd1);

        // ReLU on and off
        do_reset();
        pulse_start();
        for (int j = 0; j < 4; j++) send(relu_beat());
        chk("relu_we", 64'(we_a), 64'd1);
        chk_word("relu_on_din", din_a, relu_exp(1));
        chk_word("relu_off_din", din_b, relu_exp(0));

        // gapped input
        do_reset();
        pulse_start();
        base_we = we_cnt;
        send(mk(0));
        send(mk(1));
        repeat (3) tick();
        send(mk(2));
        repeat (7) tick();
        chk("gap_no_spurious_we", 64'(we_cnt - base_we), 64'd0);
        chk("gap_partial_busy", 64'(busy_a), 64'd1);
        send(mk(3));
        chk("gap_we", 64'(we_a), 64'd1);
        chk("gap_addr", 64'(addr_a), 64'd0);
        chk_word("gap_din", din_a, exp_basic());
        tick();
        chk("gap_we_drop", 64'(we_a), 64'd0);
        chk_word("gap_din_hold", din_a, exp_basic());

        // full frame of 4 words back-to-back
        do_reset();
        pulse_start();
        base_we = we_cnt;
        base_done = done_cnt;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 4; j++) send(mk(j) ^ {16{16'(w << 12)}});
            chk($sformatf("frame_we%0d", w), 64'(we_a), 64'd1);
            chk($sformatf("frame_addr%0d", w), 64'(addr_a), 64'(w));
            chk($sformatf("frame_done_early%0d", w), 64'(done_a), 64'd0);
            chk($sformatf("frame_busy%0d", w), 64'(busy_a), 64'd1);
        end
        chk_word("frame_last_din", din_a, exp_basic() ^ {64{16'h3000}});
        send({16{16'h0005}});
        chk("frame_done", 64'(done_a), 64'd1);
        chk("frame_busy_falls", 64'(busy_a), 64'd0);
        chk("frame_we_after", 64'(we_a), 64'd0);
        chk("frame_17th_err", 64'(err_a), 64'd1);
        tick();
        tick();
        chk("frame_done_once", 64'(done_cnt - base_done), 64'd1);
        chk("frame_we_count", 64'(we_cnt - base_we), 64'd4);

        // stray beat with no start
        do_reset();
        base_we = we_cnt;
        send(mk(0));
        chk("stray_err", 64'(err_a), 64'd1);
        chk("stray_busy", 64'(busy_a), 64'd0);
        tick();
        chk("stray_no_we", 64'(we_cnt - base_we), 64'd0);

        // start and in_valid together: beat dropped
        do_reset();
        start = 1;
        in_valid = 1;
        in_data = {16{16'hAAAA}};
        tick();
        start = 0;
        in_valid = 0;
        chk("simul_err", 64'(err_a), 64'd0);
        chk("simul_busy", 64'(busy_a), 64'd1);
        for (int j = 0; j < 3; j++) send(mk(j));
        chk("simul_no_early_we", 64'(we_a), 64'd0);
        send(mk(3));
        chk("simul_we", 64'(we_a), 64'd1);
        chk("simul_addr", 64'(addr_a), 64'd0);
        chk_word("simul_din", din_a, exp_basic());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
